// File: rtl/poly_addr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : poly_addr_gen_if
//  Description : Configuration, step handshake and result bus of the
//                polyphase read-address / phase generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface poly_addr_gen_if #(
  parameter int PHASE_W = 4,
  parameter int ADDR_W  = 10
);
  logic [PHASE_W-1:0] cfg_l;
  logic [PHASE_W-1:0] cfg_m;
  logic               cfg_load;
  logic               step_req;
  logic               step_rdy;
  logic               out_vld;
  logic [PHASE_W-1:0] phase;
  logic [ADDR_W-1:0]  addr;
  logic [PHASE_W-1:0] adv;
  logic               cfg_err;

  // Requester side: programs L/M and asks for output-sample addresses
  modport master (
    output cfg_l, cfg_m, cfg_load, step_req,
    input  step_rdy, out_vld, phase, addr, adv, cfg_err
  );

  // Generator side
  modport slave (
    input  cfg_l, cfg_m, cfg_load, step_req,
    output step_rdy, out_vld, phase, addr, adv, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/poly_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : poly_addr_gen
//  Description : Runtime-programmable L/M polyphase phase and buffer read
//                address generator. Each step adds M to the phase and
//                removes L once per cycle until the remainder is below L;
//                every removal consumes one input sample (address +1).
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_addr_gen #(
  parameter int PHASE_W = 4,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int DEF_L   = 4,
  parameter int DEF_M   = 3
) (
  input  wire              clk,
  input  wire              rn,
  poly_addr_gen_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t               state_q,   state_d;
  logic [PHASE_W-1:0]   l_q,       l_d;
  logic [PHASE_W-1:0]   m_q,       m_d;
  logic [PHASE_W-1:0]   phase_q,   phase_d;
  logic [ADDR_W-1:0]    addr_q,    addr_d;
  logic [PHASE_W-1:0]   adv_q,     adv_d;
  logic [PHASE_W:0]     acc_q,     acc_d;
  logic [ADDR_W-1:0]    waddr_q,   waddr_d;
  logic [PHASE_W-1:0]   cnt_q,     cnt_d;
  logic                 out_vld_q, out_vld_d;
  logic                 cfg_err_q, cfg_err_d;

  // A load is legal only in IDLE with a non-zero L; it takes effect before
  // a simultaneous step so the step starts from phase 0 with the new M.
  logic                 w_load_ok;
  logic [PHASE_W-1:0]   w_base_phase;
  logic [PHASE_W-1:0]   w_base_m;

  assign w_load_ok    = bus.cfg_load && (bus.cfg_l != '0);
  assign w_base_phase = w_load_ok ? '0        : phase_q;
  assign w_base_m     = w_load_ok ? bus.cfg_m : m_q;

  // State register; reset restores the default ratio and aborts any step
  always_ff @(posedge clk) begin
    if (!rn) begin
      state_q   <= S_IDLE;
      l_q       <= PHASE_W'(DEF_L);
      m_q       <= PHASE_W'(DEF_M);
      phase_q   <= '0;
      addr_q    <= '0;
      adv_q     <= '0;
      acc_q     <= '0;
      waddr_q   <= '0;
      cnt_q     <= '0;
      out_vld_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      l_q       <= l_d;
      m_q       <= m_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      adv_q     <= adv_d;
      acc_q     <= acc_d;
      waddr_q   <= waddr_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state logic: config load, step start, one L subtraction per cycle
  always_comb begin
    state_d   = state_q;
    l_d       = l_q;
    m_d       = m_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    adv_d     = adv_q;
    acc_d     = acc_q;
    waddr_d   = waddr_q;
    cnt_d     = cnt_q;
    out_vld_d = 1'b0;
    cfg_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_load) begin
          if (w_load_ok) begin
            l_d     = bus.cfg_l;
            m_d     = bus.cfg_m;
            phase_d = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (bus.step_req) begin
          acc_d   = {1'b0, w_base_phase} + {1'b0, w_base_m};
          waddr_d = addr_q;
          cnt_d   = '0;
          state_d = S_ACC;
        end
      end

      S_ACC: begin
        // Loads are never accepted mid-step
        if (bus.cfg_load) begin
          cfg_err_d = 1'b1;
        end
        if (acc_q >= {1'b0, l_q}) begin
          acc_d   = acc_q - {1'b0, l_q};
          cnt_d   = cnt_q + PHASE_W'(1);
          waddr_d = (waddr_q == C_LAST_ADDR) ? '0 : waddr_q + ADDR_W'(1);
        end else begin
          phase_d   = acc_q[PHASE_W-1:0];
          addr_d    = waddr_q;
          adv_d     = cnt_q;
          out_vld_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.step_rdy = (state_q == S_IDLE);
  assign bus.out_vld  = out_vld_q;
  assign bus.phase    = phase_q;
  assign bus.addr     = addr_q;
  assign bus.adv      = adv_q;
  assign bus.cfg_err  = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_addr_gen
//  Description : Directed self-checking bench for poly_addr_gen (DEPTH=20).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_addr_gen;

  localparam int PHASE_W = 4;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 20;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  poly_addr_gen_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W)) bus ();

  poly_addr_gen #(
    .PHASE_W(PHASE_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DEF_L  (4),
    .DEF_M  (3)
  ) u_dut (
    .clk (clk),
    .rn  (rn),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one step (optionally together with an already-driven cfg_load)
  task automatic start_step();
    chk("step_rdy_before_step", 32'(bus.step_rdy), 32'd1);
    bus.step_req = 1'b1;
    tick();
    bus.step_req = 1'b0;
    bus.cfg_load = 1'b0;
    cyc = 1;
  endtask

  // Wait for the commit pulse and check latency and results
  task automatic end_step(input string tag, input int ep, input int eadv, input int eaddr, input int elat);
    while (!bus.out_vld && cyc < 64) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"},   32'(cyc),       32'(elat));
    chk({tag, "_phase"}, 32'(bus.phase), 32'(ep));
    chk({tag, "_adv"},   32'(bus.adv),   32'(eadv));
    chk({tag, "_addr"},  32'(bus.addr),  32'(eaddr));
  endtask

  task automatic do_step(input string tag, input int ep, input int eadv, input int eaddr, input int elat);
    start_step();
    end_step(tag, ep, eadv, eaddr, elat);
  endtask

  task automatic load(input string tag, input int l, input int m, input bit exp_err);
    bus.cfg_l    = PHASE_W'(l);
    bus.cfg_m    = PHASE_W'(m);
    bus.cfg_load = 1'b1;
    tick();
    bus.cfg_load = 1'b0;
    chk({tag, "_err"}, 32'(bus.cfg_err), 32'(exp_err));
    tick();
    chk({tag, "_err_clr"}, 32'(bus.cfg_err), 32'd0);
  endtask

  initial begin
    bit seen_vld;
    bus.cfg_l    = '0;
    bus.cfg_m    = '0;
    bus.cfg_load = 1'b0;
    bus.step_req = 1'b0;
    tick();
    tick();
    rn = 1'b1;

    // Reset state
    chk("rst_rdy",   32'(bus.step_rdy), 32'd1);
    chk("rst_vld",   32'(bus.out_vld),  32'd0);
    chk("rst_phase", 32'(bus.phase),    32'd0);
    chk("rst_addr",  32'(bus.addr),     32'd0);
    chk("rst_adv",   32'(bus.adv),      32'd0);
    chk("rst_err",   32'(bus.cfg_err),  32'd0);

    // Default L=4, M=3, back-to-back
    do_step("t1s1", 3, 0, 0, 2);
    do_step("t1s2", 2, 1, 1, 3);
    do_step("t1s3", 1, 1, 2, 3);
    do_step("t1s4", 0, 1, 3, 3);
    tick();
    chk("t1_vld_pulse", 32'(bus.out_vld), 32'd0);
    chk("t1_hold_addr", 32'(bus.addr),    32'd3);

    // L=3, M=4
    load("t2_load", 3, 4, 1'b0);
    chk("t2_phase0", 32'(bus.phase), 32'd0);
    chk("t2_addr_kept", 32'(bus.addr), 32'd3);
    do_step("t2s1", 1, 1, 4, 3);
    do_step("t2s2", 2, 1, 5, 3);
    do_step("t2s3", 0, 2, 7, 4);

    // Rejected loads: cfg_l=0 in IDLE, then a load while in ACC
    load("t4_zero", 0, 7, 1'b1);
    start_step();
    bus.cfg_l    = 4'd7;
    bus.cfg_m    = 4'd1;
    bus.cfg_load = 1'b1;
    tick();
    cyc++;
    bus.cfg_load = 1'b0;
    chk("t4_acc_err", 32'(bus.cfg_err), 32'd1);
    end_step("t4s1", 1, 1, 8, 3);
    chk("t4_err_clr", 32'(bus.cfg_err), 32'd0);
    do_step("t4s2", 2, 1, 9, 3);

    // Reset during ACC (phase 2 + 4 = 6 -> two subtractions pending)
    start_step();
    rn = 1'b0;
    tick();
    rn = 1'b1;
    chk("t5_rdy",   32'(bus.step_rdy), 32'd1);
    chk("t5_vld",   32'(bus.out_vld),  32'd0);
    chk("t5_phase", 32'(bus.phase),    32'd0);
    chk("t5_addr",  32'(bus.addr),     32'd0);
    chk("t5_adv",   32'(bus.adv),      32'd0);
    seen_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_vld) seen_vld = 1'b1;
    end
    chk("t5_no_vld", 32'(seen_vld), 32'd0);
    do_step("t5s1", 3, 0, 0, 2);

    // L=1, M=15: 15 subtractions per step, address wraps at 20
    load("t3_load", 1, 15, 1'b0);
    do_step("t3s1", 0, 15, 15, 17);
    do_step("t3s2", 0, 15, 10, 17);

    // L=5, M=0: no advance, latency 2
    load("t6_load", 5, 0, 1'b0);
    do_step("t6s1", 0, 0, 10, 2);
    do_step("t6s2", 0, 0, 10, 2);
    do_step("t6s3", 0, 0, 10, 2);

    // Simultaneous load (L=2, M=3) and step: acc = 0 + 3
    bus.cfg_l    = 4'd2;
    bus.cfg_m    = 4'd3;
    bus.cfg_load = 1'b1;
    start_step();
    chk("t6_comb_err", 32'(bus.cfg_err), 32'd0);
    end_step("t6c", 1, 1, 11, 3);

    // Invalid load together with a step keeps the old config (L=2, M=3)
    bus.cfg_l    = 4'd0;
    bus.cfg_m    = 4'd9;
    bus.cfg_load = 1'b1;
    start_step();
    chk("t6_bad_comb_err", 32'(bus.cfg_err), 32'd1);
    end_step("t6d", 0, 2, 13, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
